fpm_lane_serializer: RTL



---
 rtl/fpm_lane_serializer.sv | 97 +++++++++
 1 files changed

// File: rtl/fpm_lane_serializer.sv
// Four-lane bundle serializer: takes a, b, c and d in one valid/ready handshake
// and streams them out one WIDTH-bit chunk per cycle, lane a first.
`timescale 1ns/1ps
module fpm_lane_serializer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] bundle_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state, state_n;
  logic [3:0][WIDTH-1:0]   hold, hold_n;
  logic [WIDTH-1:0]        data_n;
  logic [1:0]              idx_n;
  logic [1:0]              idx_inc;
  logic                    valid_n;
  logic [CNT_W-1:0]        cnt_n;
  logic                    fire;
  logic                    accept;

  assign fire     = out_valid && out_ready;
  assign in_ready = (state == IDLE) || (fire && out_idx == 2'd3);
  assign accept   = in_valid && in_ready;
  assign out_last = out_valid && (out_idx == 2'd3);
  assign idx_inc  = out_idx + 2'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_n = state;
    hold_n  = hold;
    data_n  = out_data;
    idx_n   = out_idx;
    valid_n = out_valid;
    cnt_n   = bundle_cnt;

    if (state == SEND && fire) begin
      if (out_idx != 2'd3) begin
        idx_n  = idx_inc;
        data_n = hold[idx_inc];
      end else begin
        cnt_n   = bundle_cnt + CNT_W'(1);
        valid_n = 1'b0;
        idx_n   = 2'd0;
        state_n = IDLE;
      end
    end

    // A new bundle overrides the wind-down above, giving gap-free reloads.
    if (accept) begin
      hold_n  = {d, c, b, a};
      data_n  = a;
      idx_n   = 2'd0;
      valid_n = 1'b1;
      state_n = SEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the holding register is small and its contents are observable via
    // out_data, so it is reset along with the control state rather than left
    // uninitialised like a RAM would be.
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      out_data   <= '0;
      out_idx    <= 2'd0;
      out_valid  <= 1'b0;
      bundle_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state      <= state_n;
      hold       <= hold_n;
      out_data   <= data_n;
      out_idx    <= idx_n;
      out_valid  <= valid_n;
      bundle_cnt <= cnt_n;
    end
  end

endmodule
